// File: rtl/ssram_arbiter.sv
// ssram_arbiter: two-master round-robin arbiter in front of the single-port SSRAM controller
// A grant is held until the controller acks, then re-arbitration waits for that ack to drop.
module ssram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_cs_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    input  logic          m1_cs_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m_dat_o,
    output logic          s_cs_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic          busy_o,
    output logic          gnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, RECOVER} state_e;
    state_e          state_q, state_d;
    logic            s_cs_q, s_cs_d, s_we_q, s_we_d;
    logic [AW-1:0]   s_adr_q, s_adr_d;
    logic [DW-1:0]   s_dat_q, s_dat_d, m_dat_q, m_dat_d;
    logic            m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d, gnt_q, gnt_d;
    logic            req, pick, grant, done;

    assign req   = m0_cs_i | m1_cs_i;
    // On a tie the master not served last wins; gnt_q doubles as last_gnt.
    assign pick  = (m0_cs_i & m1_cs_i) ? ~gnt_q : m1_cs_i;
    assign grant = (state_q == IDLE) & req;
    assign done  = (state_q == BUSY) & s_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            s_cs_q   <= 1'b0;
            s_we_q   <= 1'b0;
            s_adr_q  <= '0;
            s_dat_q  <= '0;
            m_dat_q  <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            gnt_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            s_cs_q   <= s_cs_d;
            s_we_q   <= s_we_d;
            s_adr_q  <= s_adr_d;
            s_dat_q  <= s_dat_d;
            m_dat_q  <= m_dat_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
            gnt_q    <= gnt_d;
        end
    end

    // RECOVER holds off the next grant until a stale controller ack has cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req ? BUSY : IDLE;
            BUSY:    state_d = s_ack_i ? DONE : BUSY;
            DONE:    state_d = RECOVER;
            RECOVER: state_d = s_ack_i ? RECOVER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cs_d   = grant ? 1'b1 : (done ? 1'b0 : s_cs_q);
        s_we_d   = grant ? (pick ? m1_we_i : m0_we_i) : s_we_q;
        s_adr_d  = grant ? (pick ? m1_adr_i : m0_adr_i) : s_adr_q;
        s_dat_d  = grant ? (pick ? m1_dat_i : m0_dat_i) : s_dat_q;
        gnt_d    = grant ? pick : gnt_q;
        m_dat_d  = (done & ~s_we_q) ? s_dat_i : m_dat_q;
        m0_ack_d = done & ~gnt_q;
        m1_ack_d = done & gnt_q;
    end

    assign s_cs_o   = s_cs_q;
    assign s_we_o   = s_we_q;
    assign s_adr_o  = s_adr_q;
    assign s_dat_o  = s_dat_q;
    assign m_dat_o  = m_dat_q;
    assign m0_ack_o = m0_ack_q;
    assign m1_ack_o = m1_ack_q;
    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q != IDLE);
endmodule

// File: tb/tb_ssram_arbiter.sv
// tb_ssram_arbiter: randomized bench with an SSRAM controller model and a word-array reference memory
// Read ack lands 6 cycles after grant, write 4; grant spacing 9 (read) / 7 (write).
module tb_ssram_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  mcs = 2'b00, mwe = 2'b00;
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        m0_ack, m1_ack, s_cs, s_we, s_ack, busy, gnt;
    logic [31:0] m_dat, s_adr, s_dat, s_rdat;
    int          total = 0, bad = 0, cyc = 0, ack0 = 0, ack1 = 0;
    logic [31:0] ctl_mem [256];
    logic [31:0] ref_mem [256];
    int          ctl_st = 0, ctl_cnt = 0;
    logic        ctl_ack = 1'b0;
    logic [31:0] ctl_dat = '0;

    ssram_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cs_i(mcs[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_ack_o(m0_ack),
        .m1_cs_i(mcs[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_ack_o(m1_ack),
        .m_dat_o(m_dat), .s_cs_o(s_cs), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .busy_o(busy), .gnt_o(gnt)
    );

    assign s_ack  = ctl_ack;
    assign s_rdat = ctl_dat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (m0_ack) ack0 <= ack0 + 1;
        if (m1_ack) ack1 <= ack1 + 1;
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (i * 32'h9E3779B1 + 32'h1);
    endfunction

    initial for (int i = 0; i < 256; i++) ctl_mem[i] = init_word(i);

    // Controller model: ack (level) rises 4 edges after seeing cs for reads, 2 for writes; drops once cs is seen low.
    always @(posedge clk) begin
        if (!rst_n) begin
            ctl_ack <= 1'b0;
            ctl_st  <= 0;
            ctl_dat <= '0;
        end else begin
            case (ctl_st)
                0: if (s_cs) begin ctl_cnt <= s_we ? 1 : 3; ctl_st <= 1; end
                1: if (ctl_cnt == 0) begin
                       ctl_ack <= 1'b1;
                       ctl_st  <= 2;
                       if (s_we) begin ctl_mem[s_adr[9:2]] <= s_dat; ctl_dat <= ~s_dat; end
                       else ctl_dat <= ctl_mem[s_adr[9:2]];
                   end else ctl_cnt <= ctl_cnt - 1;
                default: if (!s_cs) begin ctl_ack <= 1'b0; ctl_st <= 0; end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        mcs = 2'b00;
        repeat (3) tick;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (!busy && !s_ack) ok = 1'b1;
            else tick;
        end
    endtask

    task automatic xfer(input int m, input logic we, input logic [7:0] idx, input logic [31:0] d,
                        output int g, output int a, output logic [31:0] r, output bit ok);
        mcs[m] = 1'b1; mwe[m] = we; madr[m] = {22'd0, idx, 2'b00}; mdat[m] = d;
        g = -1; a = -1; r = '0; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick;
            if (g < 0 && s_cs && gnt == m[0]) g = cyc;
            if (m == 0 ? m0_ack : m1_ack) begin a = cyc; r = m_dat; ok = 1'b1; end
        end
        mcs[m] = 1'b0;
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b0; mcs = 2'b11; mwe = 2'b00;
        madr[0] = 32'h44; madr[1] = 32'h88; mdat[0] = 32'h1; mdat[1] = 32'h2;
        repeat (3) tick;
        total++; if ({s_cs, s_we, m0_ack, m1_ack, busy, gnt} !== 6'b000001) begin bad++;
            $display("FAIL reset_flags got=%b exp=000001", {s_cs, s_we, m0_ack, m1_ack, busy, gnt}); end
        total++; if ({s_adr, s_dat, m_dat} !== 96'd0) begin bad++;
            $display("FAIL reset_data got=%h exp=0", {s_adr, s_dat, m_dat}); end
        rst_n = 1'b1;
        tick;
        total++; if ({s_cs, gnt, busy} !== 3'b101) begin bad++;
            $display("FAIL first_grant got cs/gnt/busy=%b exp=101", {s_cs, gnt, busy}); end
        total++; if (s_adr !== 32'h44) begin bad++;
            $display("FAIL first_grant_adr got=%h exp=00000044", s_adr); end
        mcs = 2'b00;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_drain got=busy exp=idle"); end
    endtask

    task automatic test_single_read;
        int g, a, b0, b1; logic [31:0] r; bit ok;
        do_reset;
        b0 = ack0; b1 = ack1;
        xfer(0, 1'b0, 8'h10, 32'h0, g, a, r, ok);
        total++; if (!ok || g < 0 || a - g != 6) begin bad++;
            $display("FAIL read_latency got=%0d exp=6", a - g); end
        total++; if (r !== 32'hDEADBEEF) begin bad++;
            $display("FAIL read_data got=%h exp=deadbeef", r); end
        tick;
        total++; if (m0_ack !== 1'b0 || m_dat !== 32'hDEADBEEF) begin bad++;
            $display("FAIL read_pulse got ack=%b dat=%h exp ack=0 dat=deadbeef", m0_ack, m_dat); end
        total++; if (ack0 - b0 != 1 || ack1 != b1) begin bad++;
            $display("FAIL read_ack_count got m0=%0d m1=%0d exp m0=1 m1=0", ack0 - b0, ack1 - b1); end
    endtask

    task automatic test_single_write;
        int g, a, b0, b1; logic [31:0] r; bit ok, held, seen;
        wait_idle(ok);
        b0 = ack0; b1 = ack1;
        mcs[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h100; mdat[1] = 32'h12345678;
        held = 1'b1; seen = 1'b0; g = -1; a = -1;
        for (int i = 0; i < 100 && a < 0; i++) begin
            tick;
            if (s_cs) begin
                seen = 1'b1;
                if (g < 0) g = cyc;
                if (!(s_we && s_dat == 32'h12345678 && s_adr == 32'h100)) held = 1'b0;
            end
            if (m1_ack) a = cyc;
        end
        mcs[1] = 1'b0;
        if (a >= 0) ref_mem[64] = 32'h12345678;
        total++; if (!(seen && held)) begin bad++;
            $display("FAIL write_hold got seen=%b held=%b exp 1 1", seen, held); end
        total++; if (a < 0 || g < 0 || a - g != 4) begin bad++;
            $display("FAIL write_latency got=%0d exp=4", a - g); end
        tick;
        total++; if (m_dat !== 32'hDEADBEEF) begin bad++;
            $display("FAIL write_mdat_hold got=%h exp=deadbeef", m_dat); end
        total++; if (ack1 - b1 != 1 || ack0 != b0) begin bad++;
            $display("FAIL write_ack_count got m0=%0d m1=%0d exp m0=0 m1=1", ack0 - b0, ack1 - b1); end
        wait_idle(ok);
        xfer(0, 1'b0, 8'h40, 32'h0, g, a, r, ok);
        total++; if (!ok || r !== ref_mem[64]) begin bad++;
            $display("FAIL write_readback got=%h exp=%h", r, ref_mem[64]); end
    endtask

    task automatic test_back_to_back;
        int g [4]; int a, b1; logic [31:0] r; bit ok;
        logic [3:0] we_seq = 4'b1100;
        do_reset;
        b1 = ack1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] idx = 8'($urandom_range(0, 255));
            logic [31:0] d = $urandom;
            xfer(0, we_seq[k], idx, d, g[k], a, r, ok);
            if (we_seq[k] && ok) ref_mem[idx] = d;
            if (!we_seq[k]) begin
                total++; if (!ok || r !== ref_mem[idx]) begin bad++;
                    $display("FAIL b2b_data[%0d] got=%h exp=%h", k, r, ref_mem[idx]); end
            end
            mcs[0] = (k < 3);
        end
        mcs[0] = 1'b0;
        total++; if (g[1] - g[0] != 9 || g[2] - g[1] != 9) begin bad++;
            $display("FAIL b2b_read_gap got=%0d,%0d exp=9,9", g[1] - g[0], g[2] - g[1]); end
        total++; if (g[3] - g[2] != 7) begin bad++;
            $display("FAIL b2b_write_gap got=%0d exp=7", g[3] - g[2]); end
        total++; if (ack1 != b1) begin bad++; $display("FAIL b2b_m1_ack got=%0d exp=0", ack1 - b1); end
    endtask

    task automatic contention_master(input int m);
        int g, a; logic [31:0] r; bit ok;
        for (int k = 0; k < 4; k++) begin
            logic we = 1'($urandom_range(0, 1));
            logic [7:0] idx = 8'($urandom_range(0, 255));
            logic [31:0] d = $urandom;
            xfer(m, we, idx, d, g, a, r, ok);
            total++; if (!ok || g < 0 || a - g != (we ? 4 : 6) || (!we && r !== ref_mem[idx])) begin bad++;
                $display("FAIL contention_m%0d_xfer%0d got ok=%b lat=%0d dat=%h exp lat=%0d dat=%h",
                         m, k, ok, a - g, r, we ? 4 : 6, ref_mem[idx]); end
            if (we && ok) ref_mem[idx] = d;
            mcs[m] = (k < 3);
        end
    endtask

    task automatic test_contention;
        logic order [$];
        bit stale_ok = 1'b1, prev_cs = 1'b0, prev_ack = 1'b0, alt_ok = 1'b1;
        do_reset;
        fork
            contention_master(0);
            contention_master(1);
            for (int i = 0; i < 300 && order.size() < 8; i++) begin
                tick;
                if (s_cs && !prev_cs) begin
                    order.push_back(gnt);
                    if (prev_ack) stale_ok = 1'b0;
                end
                prev_cs = s_cs; prev_ack = s_ack;
            end
        join
        mcs = 2'b00;
        for (int i = 0; i < order.size(); i++) if (order[i] !== 1'(i % 2)) alt_ok = 1'b0;
        total++; if (order.size() != 8 || !alt_ok) begin bad++;
            $display("FAIL contention_order got n=%0d alt=%b exp n=8 alternating from 0", order.size(), alt_ok); end
        total++; if (!stale_ok) begin bad++;
            $display("FAIL contention_stale_ack got=grant_with_ack_high exp=ack_low_before_grant"); end
    endtask

    task automatic test_early_drop;
        int g0 = -1, a0 = -1, g1 = -1, a1 = -1, b0; logic [31:0] r = '0; bit held = 1'b1, ok;
        do_reset;
        b0 = ack0;
        mcs[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h14;
        for (int i = 0; i < 20 && g0 < 0; i++) begin tick; if (s_cs && gnt == 1'b0) g0 = cyc; end
        tick; tick;
        mcs[0] = 1'b0;
        for (int i = 0; i < 50 && a0 < 0; i++) begin
            tick;
            if (m0_ack) begin a0 = cyc; r = m_dat; end
            else if (!s_cs) held = 1'b0;
        end
        mcs[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h18; mdat[1] = $urandom;
        for (int i = 0; i < 50 && a1 < 0; i++) begin
            tick;
            if (g1 < 0 && s_cs && gnt) g1 = cyc;
            if (m1_ack) a1 = cyc;
        end
        mcs[1] = 1'b0;
        if (a1 >= 0) ref_mem[6] = mdat[1];
        total++; if (!held || g0 < 0 || a0 - g0 != 6) begin bad++;
            $display("FAIL early_drop_hold got held=%b lat=%0d exp held=1 lat=6", held, a0 - g0); end
        total++; if (r !== ref_mem[5]) begin bad++;
            $display("FAIL early_drop_data got=%h exp=%h", r, ref_mem[5]); end
        total++; if (g1 - g0 != 9 || a1 < 0) begin bad++;
            $display("FAIL early_drop_next_grant got gap=%0d exp=9", g1 - g0); end
        total++; if (ack0 - b0 != 1) begin bad++;
            $display("FAIL early_drop_ack_count got=%0d exp=1", ack0 - b0); end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_busy;
        int g, a, b0, b1; logic [31:0] r; bit ok, up = 1'b0;
        do_reset;
        mcs[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 32'h1C; mdat[1] = ~ref_mem[7];
        for (int i = 0; i < 20 && !up; i++) begin tick; up = s_cs; end
        tick;
        rst_n = 1'b0; mcs[1] = 1'b0;
        b0 = ack0; b1 = ack1;
        tick;
        total++; if ({s_cs, busy, m0_ack, m1_ack} !== 4'b0000 || gnt !== 1'b1) begin bad++;
            $display("FAIL midreset_state got cs/busy/acks=%b gnt=%b exp 0000 1",
                     {s_cs, busy, m0_ack, m1_ack}, gnt); end
        rst_n = 1'b1;
        tick; tick;
        total++; if (ack0 != b0 || ack1 != b1) begin bad++;
            $display("FAIL midreset_no_ack got m0=%0d m1=%0d exp 0 0", ack0 - b0, ack1 - b1); end
        xfer(0, 1'b0, 8'd7, 32'h0, g, a, r, ok);
        total++; if (!ok || g < 0 || a - g != 6 || r !== ref_mem[7]) begin bad++;
            $display("FAIL midreset_followup got lat=%0d dat=%h exp lat=6 dat=%h", a - g, r, ref_mem[7]); end
    endtask

    task automatic test_random;
        int last = 1;
        do_reset;
        for (int it = 0; it < 12; it++) begin
            int g [2]; int a [2]; logic [31:0] r [2]; bit ok [2]; bit idle_ok;
            logic [1:0] mask = 2'($urandom_range(1, 3));
            logic we [2]; logic [7:0] idx [2]; logic [31:0] d [2];
            int first, second;
            for (int m = 0; m < 2; m++) begin
                we[m] = 1'($urandom_range(0, 1)); idx[m] = 8'($urandom_range(0, 7)); d[m] = $urandom;
                g[m] = -1; a[m] = -1; r[m] = '0; ok[m] = 1'b0;
            end
            fork
                if (mask[0]) xfer(0, we[0], idx[0], d[0], g[0], a[0], r[0], ok[0]);
                if (mask[1]) xfer(1, we[1], idx[1], d[1], g[1], a[1], r[1], ok[1]);
            join
            first  = (mask == 2'b11) ? 1 - last : (mask[1] ? 1 : 0);
            second = 1 - first;
            if (mask == 2'b11) begin
                total++; if (!(g[first] >= 0 && g[second] > g[first])) begin bad++;
                    $display("FAIL random_grant_order[%0d] got g0=%0d g1=%0d exp first=m%0d", it, g[0], g[1], first); end
                last = second;
            end else last = first;
            for (int k = 0; k < 2; k++) begin
                int m = (k == 0) ? first : second;
                if (mask[m]) begin
                    total++; if (!ok[m] || g[m] < 0 || a[m] - g[m] != (we[m] ? 4 : 6) ||
                                 (!we[m] && r[m] !== ref_mem[idx[m]])) begin bad++;
                        $display("FAIL random_xfer[%0d] m%0d got lat=%0d dat=%h exp lat=%0d dat=%h",
                                 it, m, a[m] - g[m], r[m], we[m] ? 4 : 6, ref_mem[idx[m]]); end
                    if (we[m]) ref_mem[idx[m]] = d[m];
                end
            end
            wait_idle(idle_ok);
        end
    endtask

    initial begin
        madr[0] = '0; madr[1] = '0; mdat[0] = '0; mdat[1] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset;
        test_single_read;
        test_single_write;
        test_back_to_back;
        test_contention;
        test_early_drop;
        test_reset_mid_busy;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port SSRAM controller.
- Shares the controller between the CPU instruction-fetch bus (master 0) and data bus (master 1).
- Registers the granted request onto the controller's cs/we/adr/dat slave interface and holds it until the controller acks.
- Returns read data plus a one-cycle ack to the owning master, then waits for the controller to return to idle before the next grant.

Parameters:
- AW, 32, address width (slave uses adr[20:2]; arbiter passes the full word through)
- DW, 32, data width

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous reset, active low
- m0_cs_i  in  1  master 0 request; held high until m0_ack_o
- m0_we_i  in  1  master 0 write enable
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_ack_o  out  1  master 0 completion pulse
- m1_cs_i, m1_we_i, m1_adr_i, m1_dat_i, m1_ack_o  same as master 0, for master 1
- m_dat_o  out  DW  read data, shared by both masters, valid while the relevant ack is high
- s_cs_o  out  1  to controller cs_i
- s_we_o  out  1  to controller we_i
- s_adr_o  out  AW  to controller adr_i
- s_dat_o  out  DW  to controller dat_i
- s_dat_i  in  DW  from controller dat_o
- s_ack_i  in  1  from controller ack_o; level, high until cs drops
- busy_o  out  1  high in any state other than IDLE
- gnt_o  out  1  index of the current or last granted master

Behaviour:
- Reset (rst_ni=0 at posedge):
  - State = IDLE.
  - All outputs = 0: s_cs_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m1_ack_o, m_dat_o, busy_o.
  - last_gnt = 1, so master 0 wins the first tie; gnt_o = 1.
- Reset mid-transaction aborts immediately. The controller shares the system reset, so no recovery is required.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - If m0_cs_i or m1_cs_i is high: pick a master, latch its we/adr/dat into s_we_o/s_adr_o/s_dat_o, set s_cs_o=1, gnt_o=index, last_gnt=index. Next state = BUSY.
  - Only one requester: grant it.
  - Both requesting: grant ~last_gnt (strict alternation).
- BUSY:
  - s_cs_o and the latched fields are held constant.
  - Master inputs are ignored, including a master dropping cs_i early; the transaction still completes and acks.
  - On the first cycle s_ack_i is sampled high:
    - m_dat_o <= s_dat_i on reads; unchanged on writes.
    - s_cs_o <= 0.
    - m{gnt}_ack_o <= 1.
    - Next state = DONE.
  - No timeout: BUSY waits indefinitely.
- DONE:
  - Exactly one cycle; the ack is high for this cycle only.
  - Next edge: ack <= 0, next state = RECOVER.
- RECOVER:
  - Stays until s_ack_i is sampled low (controller back in IDLE), then next state = IDLE.
  - Prevents a stale s_ack_i from completing the next grant.
- Latency: ack is asserted 1 cycle after s_ack_i is first sampled high. With the SSRAM controller, m_ack_o rises 6 cycles after the grant edge for a read and 4 cycles for a write.
- Throughput: minimum request-to-next-grant spacing is 9 cycles for a read and 7 cycles for a write.
- Master rules:
  - A master must drop cs_i the cycle after its ack, or the arbiter treats it as a new request in IDLE.
  - A master that keeps cs_i high after its ack is re-granted only if the other master is idle (fairness preserved).
- m_dat_o holds its last read value between reads, including across writes.
- busy_o = (state != IDLE).

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with both cs high -> all outputs 0; after release, master 0 is granted first, with s_cs_o=1 and s_adr_o=m0_adr_i one cycle later.
- Single read: m0 reads 0x00000040; controller model returns 0xDEADBEEF -> m0_ack_o pulses for exactly 1 cycle, 6 cycles after grant; m_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- Single write: m1 writes 0x12345678 to 0x00000100 -> s_we_o=1, s_dat_o=0x12345678 held until ack; m1_ack_o pulses once; m_dat_o unchanged.
- Contention: both masters request continuously for 4 transactions each -> grant order 0,1,0,1,...; no master is granted twice in a row while the other waits; every s_cs_o rise is preceded by s_ack_i low.
- Early drop: m0 drops cs_i 2 cycles into BUSY -> s_cs_o stays high until s_ack_i; m0_ack_o still pulses once; the next grant waits for RECOVER to exit.
- Reset mid-BUSY: assert rst_ni=0 while s_cs_o=1 -> next cycle s_cs_o=0, state IDLE, no ack emitted; the following request completes normally.
